// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Pipelined, run-time selectable bitwise logic unit with
//            valid/ready handshakes and optional multi-beat accumulation
//            (fold of a packet into one result with a saturating beat count).
// Options  : LOGIC_UNIT_PARITY_EN adds out_parity (XOR reduction of result).
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_beats
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  // Pure per-bit operation; PASS/NOT only look at operand a.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      OP_NOTA: r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Beat counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    return c + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic             fire_in;
  logic             fire_out;
  logic [WIDTH-1:0] idle_res;
  logic [WIDTH-1:0] acc_res;
  logic [CNT_W-1:0] cnt_next;

  // Single output register: a beat is accepted whenever that register is
  // empty or is being drained this cycle.
  assign in_ready = ~out_valid_q | out_ready;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid_q & out_ready;

  assign idle_res = apply_op(in_op, in_a, in_b);
  // In a packet the new beat plays operand a, the running value operand b.
  assign acc_res  = apply_op(op_q, in_a, acc_q);
  assign cnt_next = sat_inc(cnt_q);

  // Next-state, accumulator and output-register update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
`ifdef LOGIC_UNIT_PARITY_EN
    out_parity_d = out_parity_q;
`endif

    if (fire_out) out_valid_d = 1'b0;

    if (fire_in) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_acc || in_last) begin
            out_data_d  = idle_res;
            out_beats_d = CNT_W'(1);
            out_valid_d = 1'b1;
`ifdef LOGIC_UNIT_PARITY_EN
            out_parity_d = ^idle_res;
`endif
          end else begin
            acc_d   = idle_res;
            op_d    = in_op;
            cnt_d   = CNT_W'(1);
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          if (in_last) begin
            out_data_d  = acc_res;
            out_beats_d = cnt_next;
            out_valid_d = 1'b1;
`ifdef LOGIC_UNIT_PARITY_EN
            out_parity_d = ^acc_res;
`endif
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            acc_d = acc_res;
            cnt_d = cnt_next;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_q        <= OP_AND;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
`ifdef LOGIC_UNIT_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
`ifdef LOGIC_UNIT_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Scoreboard bench for logic_unit_pipe. Two instances share one
//            stimulus stream: CNT_W=8 and CNT_W=2 (beat-count saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready, in_ready_s;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_acc, in_last;
  logic       out_valid, out_valid_s;
  logic       out_ready;
  logic [7:0] out_data, out_data_s;
  logic [7:0] out_beats;
  logic [1:0] out_beats_s;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       out_parity, out_parity_s;
`endif

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats)
`ifdef LOGIC_UNIT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_beats(out_beats_s)
`ifdef LOGIC_UNIT_PARITY_EN
    , .out_parity(out_parity_s)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] b;
    logic       p;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   total = 0;
  int   bad   = 0;
  int   last_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int beats, input logic p);
    exp_t e;
    e.d = d; e.b = 8'(beats); e.p = p;
    q_main.push_back(e);
    e.b = 8'((beats > 3) ? 3 : beats);
    q_sat.push_back(e);
  endtask

  // Issue one beat and return just after the edge on which it was taken.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic acc, input logic last);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    last_wait = n;
    if (n == 50) begin
      total++; bad++;
      $display("FAIL send_timeout: got no in_ready want in_ready=1 at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // Monitor: pops one expectation per accepted output and checks that a
  // stalled output holds its value.
  task automatic monitor();
    exp_t e;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] prev_beats = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
          chk("stall_data_hold", {24'd0, out_data}, {24'd0, prev_data});
          chk("stall_beats_hold", {24'd0, out_beats}, {24'd0, prev_beats});
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_beats = out_beats;
        if (out_valid && out_ready) begin
          if (q_main.size() == 0) begin
            total++; bad++;
            $display("FAIL main_unexpected_out: got data %0h want no output", out_data);
          end else begin
            e = q_main.pop_front();
            chk("main_data", {24'd0, out_data}, {24'd0, e.d});
            chk("main_beats", {24'd0, out_beats}, {24'd0, e.b});
`ifdef LOGIC_UNIT_PARITY_EN
            chk("main_parity", {31'd0, out_parity}, {31'd0, e.p});
`endif
          end
        end
        if (out_valid_s && out_ready) begin
          if (q_sat.size() == 0) begin
            total++; bad++;
            $display("FAIL sat_unexpected_out: got data %0h want no output", out_data_s);
          end else begin
            e = q_sat.pop_front();
            chk("sat_data", {24'd0, out_data_s}, {24'd0, e.d});
            chk("sat_beats", {30'd0, out_beats_s}, {24'd0, e.b});
`ifdef LOGIC_UNIT_PARITY_EN
            chk("sat_parity", {31'd0, out_parity_s}, {31'd0, e.p});
`endif
          end
        end
      end
    end
  endtask

  // Operand sweep for single-beat ops: a=F0, b=3C, op 0..7.
  logic [7:0] t1_exp [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0, 8'h0F};
  logic       t1_par [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] t5_a   [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_beats", {24'd0, out_beats}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: single-beat op sweep at full rate
    for (int i = 0; i < 8; i++) begin
      push_exp(t1_exp[i], 1, t1_par[i]);
      send(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
      chk("t1_no_wait", last_wait, 32'd0);
    end
    idle(3);

    // 2: backpressure with a second beat waiting
    out_ready = 1'b0;
    push_exp(8'hFF, 1, 1'b0);
    send(8'hAA, 8'h55, 3'b100, 1'b0, 1'b0);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h0F; in_op = 3'b000;
    repeat (3) begin
      @(negedge clk);
      chk("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("t2_held_data", {24'd0, out_data}, 32'h0000_00FF);
      @(posedge clk); #1;
    end
    push_exp(8'h0F, 1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_next_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_next_data", {24'd0, out_data}, 32'h0000_000F);
    idle(3);

    // 3: XOR accumulate packet, op changed mid-packet
    send(8'h01, 8'h02, 3'b100, 1'b1, 1'b0);
    send(8'h04, 8'hEE, 3'b000, 1'b0, 1'b0);
    send(8'h08, 8'h77, 3'b000, 1'b1, 1'b0);
    push_exp(8'h1F, 4, 1'b1);
    send(8'h10, 8'h00, 3'b000, 1'b0, 1'b1);
    idle(3);

    // 4: reset in the middle of a packet
    send(8'h11, 8'h22, 3'b001, 1'b1, 1'b0);
    send(8'h44, 8'h00, 3'b001, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_rst_data", {24'd0, out_data}, 32'd0);
    chk("t4_rst_beats", {24'd0, out_beats}, 32'd0);
    @(posedge clk); #1;
    push_exp(8'h0F, 1, 1'b0);
    send(8'hFF, 8'h0F, 3'b000, 1'b0, 1'b0);
    idle(3);

    // 5: six-beat OR packet (CNT_W=2 instance saturates at 3)
    for (int i = 0; i < 6; i++) begin
      if (i == 5) push_exp(8'h3F, 6, 1'b0);
      send(t5_a[i], 8'h00, 3'b001, 1'b1, (i == 5));
    end
    idle(3);

    // 6: parity vectors
    push_exp(8'h07, 1, 1'b1);
    send(8'h07, 8'hFF, 3'b000, 1'b0, 1'b0);
    push_exp(8'h03, 1, 1'b0);
    send(8'h03, 8'hFF, 3'b000, 1'b0, 1'b0);
    idle(5);

    chk("main_queue_empty", q_main.size(), 32'd0);
    chk("sat_queue_empty", q_sat.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
